axi_lite_cfg: RTL
=================

Name: axi_lite_cfg

Overview:
AXI4-Lite slave that terminates the PS general-purpose master port (M00_AXI) in the Zynq design and converts bus accesses into a flat register bank for the PL fabric. It exposes CFG_NB read/write configuration registers as a flattened output bus with per-register write pulses. It also exposes STS_NB read-only status words sampled from fabric inputs. Out-of-range or illegal accesses return SLVERR.

Parameters:
CFG_NB, 8, number of 32-bit RW config registers (word index 0..CFG_NB-1)
STS_NB, 4, number of 32-bit RO status registers (word index CFG_NB..CFG_NB+STS_NB-1)
IDX_WIDTH, 4, decoded word-index bits taken from addr[IDX_WIDTH+1:2]; CFG_NB+STS_NB <= 2**IDX_WIDTH required
CFG_RST, 32'h0, reset value of every config register

Ports:
axi_clk  in  1  single clock for all logic
axi_rst_n  in  1  reset; synchronous, active-low
s_axi_awaddr  in  32  write address; only [IDX_WIDTH+1:2] decoded, others ignored
s_axi_awprot  in  3  ignored
s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables
s_axi_wvalid / s_axi_wready  in / out  1  W handshake
s_axi_bresp  out  2  00 OKAY, 10 SLVERR
s_axi_bvalid / s_axi_bready  out / in  1  B handshake
s_axi_araddr  in  32  read address, decoded as for awaddr
s_axi_arprot  in  3  ignored
s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  00 OKAY, 10 SLVERR
s_axi_rvalid / s_axi_rready  out / in  1  R handshake
cfg_data  out  CFG_NB*32  config registers; register i at [32*i+31:32*i]
cfg_wr  out  CFG_NB  one-cycle pulse, bit i high in the cycle register i takes a new value
sts_data  in  STS_NB*32  status words; word j appears at index CFG_NB+j

Behaviour:
- Reset (axi_rst_n=0 at a rising edge): awready=0, wready=0, bvalid=0, bresp=00, arready=0, rvalid=0, rresp=00, rdata=0, cfg_wr=0, all cfg registers=CFG_RST. Any latched AW/W and any outstanding response are discarded. The first cycle after reset deasserts, awready=wready=arready=1.
- Write channel:
  - AW and W are accepted independently, in either order, and latched.
  - awready is high only when no AW is latched and bvalid=0. wready follows the same rule for W.
  - Commit occurs in the cycle after both AW and W are held, which may be the same cycle as the second handshake's following edge. In the commit cycle:
    - Register update is visible.
    - cfg_wr[idx] pulses.
    - bvalid=1 with bresp.
  - Best-case latency: AW and W both accepted on edge N; register, cfg_wr and bvalid are updated on edge N+1.
  - bvalid holds until bready. The latches clear on the commit edge, but awready and wready remain low until the B handshake completes. One outstanding write at most.
  - Byte merge: byte k is updated only if wstrb[k]=1. wstrb=0 on a valid index still returns OKAY and still pulses cfg_wr.
  - Index < CFG_NB: OKAY.
  - Index in the status range or >= CFG_NB+STS_NB: no state change, no cfg_wr pulse, SLVERR.
- Read channel:
  - arready=1 when rvalid=0. On an AR handshake at edge N, rvalid=1 at edge N+1 with rdata/rresp.
  - arready is low while rvalid=1. rdata/rresp hold stable until the R handshake. Back-to-back reads therefore run at 1 per 2 cycles maximum.
  - Index < CFG_NB returns the cfg register, OKAY.
  - Status index returns sts_data sampled in the AR-handshake cycle, OKAY.
  - Index >= CFG_NB+STS_NB returns 32'h0, SLVERR.
- Read and write channels are fully independent; both may complete in the same cycle.
- If a read address handshake occurs in the same cycle as a write commit to the same register, the read returns the pre-write value.
- Address bits outside [IDX_WIDTH+1:2] never affect decoding (aliasing is intended).

Test Plan:
1. Reset, then AW+W same cycle, addr 0x04, data 0xDEADBEEF, wstrb 0xF, bready=1:
   - bvalid one cycle later with bresp=00.
   - cfg_data[63:32]=0xDEADBEEF.
   - cfg_wr=8'b0000_0010 for exactly 1 cycle.
2. W issued 3 cycles before AW (addr 0x00, data 0x12345678), with bready held low 5 cycles:
   - wready drops after the W handshake.
   - Commit occurs the cycle after AW.
   - bvalid stays high 5 cycles.
   - awready and wready stay 0 until the B handshake.
3. Partial write to register 0 (value 0x12345678) with wdata 0xAABBCCDD, wstrb 0x5:
   - Register 0 reads 0x12BB56DD with rresp=00.
4. sts_data word 0 = 0xCAFEF00D, read addr 0x20:
   - rdata=0xCAFEF00D, OKAY.
   - Read addr 0x30 (index 12) returns 0x0 with SLVERR.
   - Write to 0x20 returns SLVERR with no cfg_wr pulse.
5. Read of register 2 with rready low 4 cycles:
   - rvalid and rdata stable.
   - arready=0 throughout.
   - A concurrent write to register 3 completes normally during this period.
6. Assert axi_rst_n=0 for 1 cycle while bvalid=1 and rvalid=1:
   - Both drop the next cycle.
   - cfg_data returns to CFG_RST.
   - A new write after reset behaves as in scenario 1.

Source files
------------

// File: rtl/axi_lite_cfg_if.sv
// AXI4-Lite bus bundle for the PS general-purpose master port feeding axi_lite_cfg.
// Data path is fixed at 32 bits; the slave modport is the register-bank side.
interface axi_lite_cfg_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

    modport master (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );
endinterface

// File: rtl/axi_lite_cfg.sv
// AXI4-Lite slave exposing CFG_NB RW config registers (with write pulses) and
// STS_NB read-only status words; illegal accesses answer SLVERR.
module axi_lite_cfg #(
    parameter int unsigned CFG_NB    = 8,
    parameter int unsigned STS_NB    = 4,
    parameter int unsigned IDX_WIDTH = 4,
    parameter logic [31:0] CFG_RST   = 32'h0
) (
    input  logic                  axi_clk,
    input  logic                  axi_rst_n,
    axi_lite_cfg_if.slave         s_axi,
    output logic [CFG_NB*32-1:0]  cfg_data,
    output logic [CFG_NB-1:0]     cfg_wr,
    input  logic [STS_NB*32-1:0]  sts_data
);

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_AW,
        WR_W,
        WR_BOTH,
        WR_RESP
    } wr_state_t;

    wr_state_t             wr_st;
    logic [IDX_WIDTH-1:0]  aw_idx;
    logic [31:0]           aw_idx_u;
    logic [31:0]           wdata_l;
    logic [3:0]            wstrb_l;
    logic [31:0]           cfg_q [CFG_NB];
    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic [31:0]           ar_idx_u;
    logic [31:0]           rd_data;
    logic                  rd_err;
    logic                  unused_bits;

    assign aw_hs    = s_axi.awvalid && s_axi.awready;
    assign w_hs     = s_axi.wvalid && s_axi.wready;
    assign ar_hs    = s_axi.arvalid && s_axi.arready;
    assign aw_idx_u = 32'(aw_idx);
    assign ar_idx_u = 32'(s_axi.araddr[IDX_WIDTH+1:2]);

    // Address bits outside the word index alias by design.
    assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                           s_axi.awaddr[31:IDX_WIDTH+2], s_axi.awaddr[1:0],
                           s_axi.araddr[31:IDX_WIDTH+2], s_axi.araddr[1:0]};

    always_comb begin
        cfg_data = '0;
        for (int unsigned i = 0; i < CFG_NB; i++) begin
            cfg_data[32*i +: 32] = cfg_q[i];
        end
    end

    // Write channel: readies are registered and reopen only after the B handshake.
    always_ff @(posedge axi_clk) begin
        if (!axi_rst_n) begin
            wr_st         <= WR_IDLE;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            s_axi.bresp   <= 2'b00;
            cfg_wr        <= '0;
            aw_idx        <= '0;
            wdata_l       <= '0;
            wstrb_l       <= '0;
            for (int unsigned i = 0; i < CFG_NB; i++) begin
                cfg_q[i] <= CFG_RST;
            end
        end else begin
            cfg_wr <= '0;
            if (aw_hs) begin
                aw_idx <= s_axi.awaddr[IDX_WIDTH+1:2];
            end
            if (w_hs) begin
                wdata_l <= s_axi.wdata;
                wstrb_l <= s_axi.wstrb;
            end
            case (wr_st)
                WR_IDLE: begin
                    s_axi.awready <= !aw_hs;
                    s_axi.wready  <= !w_hs;
                    if (aw_hs && w_hs) begin
                        wr_st <= WR_BOTH;
                    end else if (aw_hs) begin
                        wr_st <= WR_AW;
                    end else if (w_hs) begin
                        wr_st <= WR_W;
                    end
                end
                WR_AW: begin
                    if (w_hs) begin
                        wr_st        <= WR_BOTH;
                        s_axi.wready <= 1'b0;
                    end
                end
                WR_W: begin
                    if (aw_hs) begin
                        wr_st         <= WR_BOTH;
                        s_axi.awready <= 1'b0;
                    end
                end
                WR_BOTH: begin
                    wr_st        <= WR_RESP;
                    s_axi.bvalid <= 1'b1;
                    s_axi.bresp  <= (aw_idx_u < CFG_NB) ? 2'b00 : 2'b10;
                    for (int unsigned i = 0; i < CFG_NB; i++) begin
                        if (aw_idx_u == i) begin
                            cfg_wr[i] <= 1'b1;
                            for (int unsigned k = 0; k < 4; k++) begin
                                if (wstrb_l[k]) begin
                                    cfg_q[i][8*k +: 8] <= wdata_l[8*k +: 8];
                                end
                            end
                        end
                    end
                end
                WR_RESP: begin
                    if (s_axi.bready) begin
                        wr_st         <= WR_IDLE;
                        s_axi.bvalid  <= 1'b0;
                        s_axi.awready <= 1'b1;
                        s_axi.wready  <= 1'b1;
                    end
                end
                default: wr_st <= WR_IDLE;
            endcase
        end
    end

    // cfg_q is read before this edge's commit, so a colliding read sees the old value.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b1;
        for (int unsigned i = 0; i < CFG_NB; i++) begin
            if (ar_idx_u == i) begin
                rd_data = cfg_q[i];
                rd_err  = 1'b0;
            end
        end
        for (int unsigned j = 0; j < STS_NB; j++) begin
            if (ar_idx_u == CFG_NB + j) begin
                rd_data = sts_data[32*j +: 32];
                rd_err  = 1'b0;
            end
        end
    end

    always_ff @(posedge axi_clk) begin
        if (!axi_rst_n) begin
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
            s_axi.rresp   <= 2'b00;
        end else if (ar_hs) begin
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b1;
            s_axi.rdata   <= rd_data;
            s_axi.rresp   <= rd_err ? 2'b10 : 2'b00;
        end else begin
            if (s_axi.rvalid && s_axi.rready) begin
                s_axi.rvalid <= 1'b0;
            end
            s_axi.arready <= !s_axi.rvalid || s_axi.rready;
        end
    end

endmodule
